// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: defaults, stage-record
// field widths and the forward-select encoding for "read the register file".
package pipe_pkg;
  localparam int CTRL_W_DEF = 17;
  localparam int DEPTH_DEF  = 3;
  localparam int NSRC_DEF   = 2;
  localparam int RD_W       = 5;
  localparam int CNT_W      = 16;
  localparam int FW_REGFILE = 0;

  typedef enum logic [1:0] {
    PIPE_RUN,
    PIPE_HAZ,
    PIPE_FLUSH,
    PIPE_FREEZE
  } pipe_mode_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the decode front end and the hazard controller: ID-stage
// operands in, stage records and front-end enables/forward selects out.
interface pipeline_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NSRC   = NSRC_DEF
);
  localparam int FW = $clog2(DEPTH + 1);

  logic [CTRL_W-1:0]       id_ctrl;
  logic [RD_W-1:0]         id_rd;
  logic                    id_rf_en;
  logic                    id_load;
  logic                    id_store;
  logic                    id_valid;
  logic [NSRC*RD_W-1:0]    id_rs;
  logic [NSRC-1:0]         id_rs_used;
  logic                    flush;
  logic                    ext_stall;

  logic [DEPTH*CTRL_W-1:0] stg_ctrl;
  logic [DEPTH*RD_W-1:0]   stg_rd;
  logic [DEPTH-1:0]        stg_valid;
  logic                    pc_le;
  logic                    npc_le;
  logic                    if_id_le;
  logic                    if_id_clr;
  logic                    cu_s;
  logic [NSRC*FW-1:0]      fwd_sel;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output id_ctrl, id_rd, id_rf_en, id_load, id_store, id_valid,
           id_rs, id_rs_used, flush, ext_stall,
    input  stg_ctrl, stg_rd, stg_valid, pc_le, npc_le, if_id_le,
           if_id_clr, cu_s, fwd_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ctrl, id_rd, id_rf_en, id_load, id_store, id_valid,
           id_rs, id_rs_used, flush, ext_stall,
    output stg_ctrl, stg_rd, stg_valid, pc_le, npc_le, if_id_le,
           if_id_clr, cu_s, fwd_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// One post-ID stage record; clr with le turns the incoming slot into a bubble,
// le low freezes the record.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              le,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [RD_W-1:0]   d_rd,
  input  logic              d_rf_en,
  input  logic              d_load,
  input  logic              d_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [RD_W-1:0]   q_rd,
  output logic              q_rf_en,
  output logic              q_load,
  output logic              q_valid
);
  always_ff @(posedge clk) begin
    if (reset || (le && clr)) begin
      q_ctrl  <= '0;
      q_rd    <= '0;
      q_rf_en <= 1'b0;
      q_load  <= 1'b0;
      q_valid <= 1'b0;
    end else if (le) begin
      q_ctrl  <= d_ctrl;
      q_rd    <= d_rd;
      q_rf_en <= d_rf_en;
      q_load  <= d_load;
      q_valid <= d_valid;
    end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control: carries stage records, detects load-use hazards, picks
// forwarding sources and counts stall/flush cycles.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NSRC   = NSRC_DEF
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int FW = $clog2(DEPTH + 1);

  // Index 0 is the ID stage, 1..DEPTH are the registered stages.
  logic [CTRL_W-1:0] s_ctrl  [DEPTH+1];
  logic [RD_W-1:0]   s_rd    [DEPTH+1];
  logic              s_rf_en [DEPTH+1];
  logic              s_load  [DEPTH+1];
  logic              s_valid [DEPTH+1];

  logic [NSRC-1:0]   ld_match;
  logic              hazard;
  pipe_mode_e        mode;
  logic              front_le;
  logic              stage_le;
  logic              stage1_clr;
  logic [FW-1:0]     fwd_pick;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign s_ctrl[0]  = bus.id_ctrl;
  assign s_rd[0]    = bus.id_rd;
  assign s_rf_en[0] = bus.id_rf_en;
  assign s_load[0]  = bus.id_load;
  assign s_valid[0] = bus.id_valid;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stg
    pipe_stage_reg #(.CTRL_W(CTRL_W)) u_stg (
      .clk     (clk),
      .reset   (reset),
      .le      (stage_le),
      .clr     ((k == 1) ? stage1_clr : 1'b0),
      .d_ctrl  (s_ctrl[k-1]),
      .d_rd    (s_rd[k-1]),
      .d_rf_en (s_rf_en[k-1]),
      .d_load  (s_load[k-1]),
      .d_valid (s_valid[k-1]),
      .q_ctrl  (s_ctrl[k]),
      .q_rd    (s_rd[k]),
      .q_rf_en (s_rf_en[k]),
      .q_load  (s_load[k]),
      .q_valid (s_valid[k])
    );
  end

  always_comb begin
    bus.stg_ctrl  = '0;
    bus.stg_rd    = '0;
    bus.stg_valid = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      bus.stg_ctrl[(k-1)*CTRL_W +: CTRL_W] = s_ctrl[k];
      bus.stg_rd[(k-1)*RD_W +: RD_W]       = s_rd[k];
      bus.stg_valid[k-1]                   = s_valid[k];
    end
  end

  // The store-data operand (last source) is forwarded at MEM, so it never stalls a store.
  always_comb begin
    ld_match = '0;
    for (int i = 0; i < NSRC; i++) begin
      ld_match[i] = s_valid[1] && s_load[1] && s_rf_en[1] && (s_rd[1] != '0) &&
                    (s_rd[1] == bus.id_rs[i*RD_W +: RD_W]) && bus.id_rs_used[i];
    end
    if (bus.id_store) ld_match[NSRC-1] = 1'b0;
    hazard = bus.id_valid && (|ld_match);
  end

  always_comb begin
    mode = PIPE_RUN;
    if (bus.ext_stall)  mode = PIPE_FREEZE;
    else if (bus.flush) mode = PIPE_FLUSH;
    else if (hazard)    mode = PIPE_HAZ;
  end

  always_comb begin
    front_le      = 1'b1;
    bus.cu_s      = 1'b0;
    bus.if_id_clr = 1'b0;
    if (reset) begin
      bus.if_id_clr = 1'b1;
    end else begin
      case (mode)
        PIPE_FREEZE: front_le = 1'b0;
        PIPE_FLUSH:  bus.if_id_clr = 1'b1;
        PIPE_HAZ: begin
          front_le = 1'b0;
          bus.cu_s = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_le    = front_le;
  assign bus.npc_le   = front_le;
  assign bus.if_id_le = front_le;
  assign stage_le     = (mode != PIPE_FREEZE);
  assign stage1_clr   = (mode == PIPE_FLUSH) || (mode == PIPE_HAZ);

  // Scan oldest to youngest so the youngest eligible producer is the last write.
  always_comb begin
    bus.fwd_sel = '0;
    fwd_pick    = FW'(FW_REGFILE);
    for (int i = 0; i < NSRC; i++) begin
      fwd_pick = FW'(FW_REGFILE);
      for (int k = DEPTH; k >= 1; k--) begin
        if (s_valid[k] && s_rf_en[k] && (s_rd[k] != '0) &&
            (s_rd[k] == bus.id_rs[i*RD_W +: RD_W]) && !((k == 1) && s_load[k]))
          fwd_pick = FW'(k);
      end
      if (!reset) bus.fwd_sel[i*FW +: FW] = fwd_pick;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (mode == PIPE_HAZ)   stall_cnt_q <= sat_inc(stall_cnt_q);
      if (mode == PIPE_FLUSH) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table walked through a
// 3-stage pipeline plus hand sequences for ctrl transport, saturation and reset.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CTRL_W(17), .DEPTH(3), .NSRC(2)) bus ();

  pipeline_hazard_ctrl #(.CTRL_W(17), .DEPTH(3), .NSRC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rf_en, load, store, valid;
    logic [4:0]  rs0, rs1;
    logic [1:0]  used;
    logic        flush, estall;
    logic        le, cu, clr;
    logic [1:0]  f0, f1;
    logic [2:0]  vld;
    logic [4:0]  rd_ex;
    logic [15:0] scnt, fcnt;
  } vec_t;

  vec_t tbl [23];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(
    input logic [4:0] rd, input logic rf_en, input logic load, input logic store,
    input logic valid, input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
    input logic flush, input logic estall, input logic le, input logic cu, input logic clr,
    input logic [1:0] f0, input logic [1:0] f1, input logic [2:0] vld,
    input logic [4:0] rd_ex, input logic [15:0] scnt, input logic [15:0] fcnt);
    vec_t v;
    v.rd = rd; v.rf_en = rf_en; v.load = load; v.store = store; v.valid = valid;
    v.rs0 = rs0; v.rs1 = rs1; v.used = used; v.flush = flush; v.estall = estall;
    v.le = le; v.cu = cu; v.clr = clr; v.f0 = f0; v.f1 = f1; v.vld = vld;
    v.rd_ex = rd_ex; v.scnt = scnt; v.fcnt = fcnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic rf_en, input logic load,
                       input logic store, input logic valid, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [1:0] used,
                       input logic flush, input logic estall);
    bus.id_ctrl    = {12'hA5A, rd};
    bus.id_rd      = rd;
    bus.id_rf_en   = rf_en;
    bus.id_load    = load;
    bus.id_store   = store;
    bus.id_valid   = valid;
    bus.id_rs      = {rs1, rs0};
    bus.id_rs_used = used;
    bus.flush      = flush;
    bus.ext_stall  = estall;
  endtask

  function automatic logic [63:0] snap();
    return {15'd0, bus.pc_le, bus.npc_le, bus.if_id_le, bus.cu_s, bus.if_id_clr,
            bus.fwd_sel, bus.stg_valid, bus.stg_rd[4:0], bus.stall_cnt, bus.flush_cnt};
  endfunction

  initial begin
    //           rd rf ld st vl rs0 rs1 used   fl es  le cu cl f0 f1 vld    rdex s  f
    tbl[0]  = mk(5, 1, 1, 0, 1, 1,  0,  2'b01, 0, 0,  1, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    tbl[1]  = mk(7, 1, 0, 0, 1, 5,  2,  2'b11, 0, 0,  0, 1, 0, 0, 0, 3'b001, 5, 0, 0);
    tbl[2]  = mk(7, 1, 0, 0, 1, 5,  2,  2'b11, 0, 0,  1, 0, 0, 2, 0, 3'b010, 0, 1, 0);
    tbl[3]  = mk(3, 1, 0, 0, 1, 1,  1,  2'b11, 0, 0,  1, 0, 0, 0, 0, 3'b101, 7, 1, 0);
    tbl[4]  = mk(3, 1, 0, 0, 1, 4,  4,  2'b11, 0, 0,  1, 0, 0, 0, 0, 3'b011, 3, 1, 0);
    tbl[5]  = mk(9, 1, 0, 0, 1, 3,  7,  2'b11, 0, 0,  1, 0, 0, 1, 3, 3'b111, 3, 1, 0);
    tbl[6]  = mk(0, 1, 1, 0, 1, 2,  0,  2'b01, 0, 0,  1, 0, 0, 0, 0, 3'b111, 9, 1, 0);
    tbl[7]  = mk(6, 1, 0, 0, 1, 0,  9,  2'b11, 0, 0,  1, 0, 0, 0, 2, 3'b111, 0, 1, 0);
    tbl[8]  = mk(8, 1, 1, 0, 1, 1,  0,  2'b01, 0, 0,  1, 0, 0, 0, 0, 3'b111, 6, 1, 0);
    tbl[9]  = mk(0, 0, 0, 1, 1, 2,  8,  2'b11, 0, 0,  1, 0, 0, 0, 0, 3'b111, 8, 1, 0);
    tbl[10] = mk(8, 1, 1, 0, 1, 1,  0,  2'b01, 0, 0,  1, 0, 0, 0, 0, 3'b111, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 1, 1, 8,  1,  2'b11, 0, 0,  0, 1, 0, 3, 0, 3'b111, 8, 1, 0);
    tbl[12] = mk(0, 0, 0, 1, 1, 8,  1,  2'b11, 0, 0,  1, 0, 0, 2, 0, 3'b110, 0, 2, 0);
    tbl[13] = mk(4, 1, 1, 0, 1, 1,  0,  2'b01, 0, 0,  1, 0, 0, 0, 0, 3'b101, 0, 2, 0);
    tbl[14] = mk(2, 1, 0, 0, 1, 4,  4,  2'b11, 1, 0,  1, 0, 1, 0, 0, 3'b011, 4, 2, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,  0,  2'b00, 0, 0,  1, 0, 0, 0, 0, 3'b110, 0, 2, 1);
    tbl[16] = mk(5, 1, 1, 0, 1, 1,  0,  2'b01, 0, 0,  1, 0, 0, 0, 0, 3'b100, 0, 2, 1);
    tbl[17] = mk(7, 1, 0, 0, 1, 5,  2,  2'b11, 0, 1,  0, 0, 0, 0, 0, 3'b001, 5, 2, 1);
    tbl[18] = mk(7, 1, 0, 0, 1, 5,  2,  2'b11, 1, 1,  0, 0, 0, 0, 0, 3'b001, 5, 2, 1);
    tbl[19] = mk(7, 1, 0, 0, 1, 5,  2,  2'b11, 0, 1,  0, 0, 0, 0, 0, 3'b001, 5, 2, 1);
    tbl[20] = mk(7, 1, 0, 0, 1, 5,  2,  2'b11, 0, 0,  0, 1, 0, 0, 0, 3'b001, 5, 2, 1);
    tbl[21] = mk(7, 1, 0, 0, 1, 5,  2,  2'b11, 0, 0,  1, 0, 0, 2, 0, 3'b010, 0, 3, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 0,  0,  2'b00, 0, 0,  1, 0, 0, 0, 0, 3'b101, 7, 3, 1);

    // Reset with a busy ID stage.
    reset = 1'b1;
    drive(5, 1, 1, 0, 1, 1, 0, 2'b01, 1, 1);
    @(negedge clk);
    #1;
    check("reset_front", {59'd0, bus.pc_le, bus.npc_le, bus.if_id_le, bus.cu_s, bus.if_id_clr},
          {59'd0, 5'b11101});
    @(negedge clk);
    check("reset_state", {13'd0, bus.stg_valid, bus.fwd_sel, bus.stall_cnt, bus.flush_cnt}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tbl[i].rd, tbl[i].rf_en, tbl[i].load, tbl[i].store, tbl[i].valid,
            tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].flush, tbl[i].estall);
      #1;
      check($sformatf("vec%0d", i), snap(),
            {15'd0, tbl[i].le, tbl[i].le, tbl[i].le, tbl[i].cu, tbl[i].clr,
             tbl[i].f1, tbl[i].f0, tbl[i].vld, tbl[i].rd_ex, tbl[i].scnt, tbl[i].fcnt});
    end

    // Control bundle transport and bubble insertion.
    @(negedge clk);
    drive(5, 1, 1, 0, 1, 1, 0, 2'b01, 0, 0);
    @(negedge clk);
    #1;
    check("ctrl_ex", {47'd0, bus.stg_ctrl[16:0]}, {47'd0, 12'hA5A, 5'd5});
    drive(7, 1, 0, 0, 1, 5, 2, 2'b11, 0, 0);
    #1;
    check("ctrl_haz", {63'd0, bus.cu_s}, 64'd1);
    @(negedge clk);
    #1;
    check("ctrl_bubble", {30'd0, bus.stg_ctrl[33:0]}, {30'd0, 12'hA5A, 5'd5, 17'd0});
    check("ctrl_scnt", {48'd0, bus.stall_cnt}, 64'd4);

    // Saturation of the stall counter.
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    check("sat_preload", {48'd0, bus.stall_cnt}, 64'h0000_0000_0000_FFFE);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      drive(5, 1, 1, 0, 1, 1, 0, 2'b01, 0, 0);
      @(negedge clk);
      drive(7, 1, 0, 0, 1, 5, 2, 2'b11, 0, 0);
      #1;
      check($sformatf("sat_haz%0d", h), {63'd0, bus.cu_s}, 64'd1);
    end
    @(negedge clk);
    #1;
    check("sat_hold", {48'd0, bus.stall_cnt}, 64'h0000_0000_0000_FFFF);

    // Reset asserted while frozen with a pending hazard.
    drive(5, 1, 1, 0, 1, 1, 0, 2'b01, 0, 0);
    @(negedge clk);
    drive(7, 1, 0, 0, 1, 5, 2, 2'b11, 1, 1);
    reset = 1'b1;
    #1;
    check("rst_stall_front", {59'd0, bus.pc_le, bus.npc_le, bus.if_id_le, bus.cu_s, bus.if_id_clr},
          {59'd0, 5'b11101});
    @(negedge clk);
    #1;
    check("rst_stall_state", {29'd0, bus.stg_valid, bus.stall_cnt, bus.flush_cnt}, 64'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
